pp_accum_seq: RTL and testbench

PP_ACCUM_SEQ -- requirements
Module: pp_accum_seq

---
 rtl/pp_accum_seq.sv | 117 +++++++++++
 tb/tb_pp_accum_seq.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_accum_seq.sv
// Booth partial-product accumulator.
// Captures a set of NUM_PP partial products and sums PP_PER_CYC of them
// per clock, each sign-extended and weighted by 4^i. The final sum is
// presented with a valid/ready handshake.
module pp_accum_seq #(
  parameter int NUM_PP     = 16,
  parameter int PP_W       = 33,
  parameter int OUT_W      = 64,
  parameter int PP_PER_CYC = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_PP*PP_W-1:0] pp_flat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       product,
  output logic                   busy,
  output logic [3:0]             step
);

  localparam int STEPS = NUM_PP / PP_PER_CYC;
  localparam int IDX_W = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [PP_W-1:0]   bank [NUM_PP];
  logic [OUT_W-1:0]  acc, acc_nxt, product_r;
  logic [3:0]        step_r;
  logic              accept, last_step;
  logic [IDX_W-1:0]  idx;
  logic [PP_W-1:0]   pp_sel;
  logic [OUT_W-1:0]  pp_ext;

  assign accept    = (state == IDLE) && in_valid && !reset;
  assign last_step = (step_r == 4'(STEPS - 1));

  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign step      = (state == ACCUM) ? step_r : '0;
  assign product   = product_r;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)    state_nxt = ACCUM;
      ACCUM:   if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sum of this step's partial products, each sign-extended and shifted by 2*i
  always_comb begin
    acc_nxt = acc;
    idx     = '0;
    pp_sel  = '0;
    pp_ext  = '0;
    for (int unsigned j = 0; j < PP_PER_CYC; j++) begin
      idx     = IDX_W'(int'(step_r) * PP_PER_CYC + int'(j));
      pp_sel  = bank[idx];
      pp_ext  = {{(OUT_W-PP_W){pp_sel[PP_W-1]}}, pp_sel};
      acc_nxt = acc_nxt + (pp_ext << (2 * idx));
    end
  end

  // Input bank: sampled only on the accepting edge
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned i = 0; i < NUM_PP; i++)
        bank[i] <= pp_flat[i*PP_W +: PP_W];
    end
  end

  // Accumulator, step counter and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      product_r <= '0;
      step_r    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            acc    <= '0;
            step_r <= '0;
          end
        end
        ACCUM: begin
          acc <= acc_nxt;
          if (last_step) begin
            product_r <= acc_nxt;
            step_r    <= '0;
          end else begin
            step_r <= step_r + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_accum_seq.sv
// Scoreboard bench for pp_accum_seq: the driver pushes expected products on
// acceptance; an independent monitor checks outputs against the queue.
module tb_pp_accum_seq;

  localparam int NUM_PP = 16;
  localparam int PP_W   = 33;
  localparam int OUT_W  = 64;
  localparam int PPC    = 2;
  localparam int STEPS  = NUM_PP / PPC;
  localparam int FW     = NUM_PP * PP_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [FW-1:0]     pp_flat;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  product;
  logic              busy;
  logic [3:0]        step;

  typedef struct {
    logic [63:0] exp;
    int          edge_n;
  } ent_t;

  ent_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          mon_en   = 1'b0;
  logic [63:0] model_product = '0;
  bit          was_hold  = 1'b0;
  bit          first_done = 1'b1;

  pp_accum_seq #(
    .NUM_PP     (NUM_PP),
    .PP_W       (PP_W),
    .OUT_W      (OUT_W),
    .PP_PER_CYC (PPC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pp_flat   (pp_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy),
    .step      (step)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Reference: product = sum over i of signed(pp_i) * 4^i, modulo 2^64
  function automatic logic [63:0] model(input logic [FW-1:0] f);
    logic [63:0]            s;
    logic signed [PP_W-1:0] p;
    longint                 v;
    s = '0;
    for (int i = 0; i < NUM_PP; i++) begin
      p = f[i*PP_W +: PP_W];
      v = p;
      s = s + 64'(v * (longint'(1) << (2 * i)));
    end
    return s;
  endfunction

  function automatic logic [FW-1:0] rand_flat();
    logic [FW-1:0] f;
    for (int i = 0; i < NUM_PP; i++)
      f[i*PP_W +: PP_W] = {1'($urandom_range(0, 1)), 32'($urandom)};
    return f;
  endfunction

  // Monitor: compares DUT outputs with the scoreboard every cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (reset) begin
        model_product = '0;
        was_hold      = 1'b0;
        first_done    = 1'b1;
      end else begin
        chk("in_ready_vs_busy", in_ready, !busy);
        if (was_hold) chk("valid_hold", out_valid, 1'b1);
        if (out_valid) begin
          chk("busy_done", busy, 1'b1);
          chk("step_done", step, 4'd0);
          if (sb.size() == 0) begin
            fail_now("spurious_valid", "out_valid=1 with no pending operation");
          end else begin
            if (first_done) chk("latency", 64'(cyc - sb[0].edge_n), 64'(STEPS));
            chk("product", product, sb[0].exp);
            if (out_ready) begin
              model_product = sb[0].exp;
              void'(sb.pop_front());
              first_done = 1'b1;
            end else begin
              first_done = 1'b0;
            end
          end
          was_hold = !out_ready;
        end else begin
          was_hold   = 1'b0;
          first_done = 1'b1;
          chk("product_retained", product, model_product);
          if (busy) begin
            if (sb.size() == 0) fail_now("spurious_busy", "busy=1 with no pending operation");
            else chk("step_accum", step, 64'(cyc - sb[0].edge_n));
          end else begin
            chk("step_idle", step, 4'd0);
          end
        end
      end
    end
  end

  task automatic wait_accept(output int e, output bit ok);
    ok = 1'b0;
    e  = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (in_ready && in_valid) begin
        e  = cyc + 1;
        ok = 1'b1;
        return;
      end
    end
  endtask

  // One operation; DONE is held with out_ready=0 for 'hold' extra cycles
  task automatic run_op(input logic [FW-1:0] flat, input logic [63:0] exp, input int hold);
    int e;
    bit ok;
    pp_flat   = flat;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    wait_accept(e, ok);
    if (!ok) begin
      fail_now("accept_timeout", "in_ready never seen");
      @(posedge clk); #1;
      in_valid = 1'b0;
      return;
    end
    sb.push_back('{exp: exp, edge_n: e});
    @(posedge clk); #1;
    in_valid = 1'b0;
    pp_flat  = rand_flat();
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail_now("done_timeout", "out_valid never seen");
      @(posedge clk); #1;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      pp_flat  = rand_flat();
      @(negedge clk);
      chk("in_ready_done", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic reset_mid_op();
    int e;
    bit ok;
    pp_flat   = rand_flat();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    wait_accept(e, ok);
    if (!ok) begin
      fail_now("accept_timeout_rst", "in_ready never seen");
      return;
    end
    sb.push_back('{exp: model(pp_flat), edge_n: e});
    @(posedge clk); #1;
    in_valid = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (step == 4'd3) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("step3_timeout", "step never reached 3");
    reset    = 1'b1;
    in_valid = 1'b1;
    pp_flat  = rand_flat();
    @(posedge clk); #1;
    sb.delete();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_step", step, 4'd0);
    chk("rst_product", product, 64'd0);
    chk("rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic back_to_back();
    int e1, e2;
    bit ok1, ok2;
    logic [FW-1:0] b;
    b         = rand_flat();
    pp_flat   = rand_flat();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    wait_accept(e1, ok1);
    if (ok1) sb.push_back('{exp: model(pp_flat), edge_n: e1});
    @(posedge clk); #1;
    pp_flat = b;
    wait_accept(e2, ok2);
    if (ok2) sb.push_back('{exp: model(b), edge_n: e2});
    if (ok1 && ok2) chk("initiation_interval", 64'(e2 - e1), 64'(STEPS + 2));
    else fail_now("b2b_timeout", "back-to-back accept not seen");
    @(posedge clk); #1;
    in_valid = 1'b0;
    pp_flat  = rand_flat();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk("b2b_drained", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] f;
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    pp_flat   = rand_flat();
    repeat (3) @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_step", step, 4'd0);
    chk("reset_product", product, 64'd0);
    chk("reset_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    mon_en   = 1'b1;

    f = '0;
    f[0] = 1'b1;
    run_op(f, 64'h0000_0000_0000_0001, 0);

    f = '0;
    f[15*PP_W +: PP_W] = '1;
    run_op(f, 64'hFFFF_FFFF_C000_0000, 1);

    f = '0;
    for (int i = 0; i < NUM_PP; i++) f[i*PP_W] = 1'b1;
    run_op(f, 64'h0000_0000_5555_5555, 0);

    f = rand_flat();
    run_op(f, model(f), 5);

    reset_mid_op();
    f = rand_flat();
    run_op(f, model(f), 0);

    back_to_back();

    for (int n = 0; n < 25; n++) begin
      f = rand_flat();
      run_op(f, model(f), int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
